// File: rtl/multicrack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicrack_ctrl
// Brief    : N-engine ARC4 key-search coordinator: broadcast ciphertext copy,
//            common engine start, lowest-index winner select and abort.
// Revision : 1.0 - initial release
// ============================================================================
module multicrack_ctrl #(
    parameter  int N_ENG = 2,
    parameter  int KEY_W = 24,
    parameter  int AW    = 8,
    parameter  int DW    = 8,
    localparam int IDX_W = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    output logic [KEY_W-1:0]       key,
    output logic                   key_valid,
    output logic [IDX_W-1:0]       found_idx,
    output logic [AW-1:0]          ct_addr,
    input  logic [DW-1:0]          ct_rddata,
    output logic                   bc_wren,
    output logic [AW-1:0]          bc_addr,
    output logic [DW-1:0]          bc_wrdata,
    output logic [N_ENG-1:0]       eng_start,
    output logic                   eng_stop,
    input  logic [N_ENG-1:0]       eng_done,
    input  logic [N_ENG-1:0]       eng_key_valid,
    input  logic [N_ENG*KEY_W-1:0] eng_key
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDLEN = 3'd1,
        S_COPY  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [N_ENG-1:0] c_all_ones = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_wr_addr;
    logic [AW-1:0]      r_ct_addr;
    logic [AW-1:0]      w_rd_len;
    logic [AW-1:0]      w_len;
    logic               w_last_wr;
    logic [N_ENG-1:0]   r_done_seen;
    logic [N_ENG-1:0]   w_done_acc;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic [KEY_W-1:0]   w_hit_key;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_valid;
    logic [IDX_W-1:0]   r_found_idx;

    // The length byte is DW wide but bounds an AW-wide address range.
    generate
        if (DW >= AW) begin : g_len_trunc
            assign w_rd_len = ct_rddata[AW-1:0];
        end else begin : g_len_ext
            assign w_rd_len = {{(AW-DW){1'b0}}, ct_rddata};
        end
    endgenerate

    // The first COPY cycle sees the length byte live on ct_rddata.
    assign w_len      = (r_wr_addr == '0) ? w_rd_len : r_len;
    assign w_last_wr  = (r_wr_addr == w_len);
    assign w_done_acc = r_done_seen | eng_done;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_key = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (eng_done[i] && eng_key_valid[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
                w_hit_key = eng_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rdy          = 1'b0;
        bc_wren      = 1'b0;
        bc_wrdata    = '0;
        eng_start    = '0;
        eng_stop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    w_state_next = S_RDLEN;
                end
            end
            S_RDLEN: begin
                w_state_next = S_COPY;
            end
            S_COPY: begin
                bc_wren   = 1'b1;
                bc_wrdata = ct_rddata;
                if (w_last_wr) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                eng_start    = c_all_ones;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_hit) begin
                    w_state_next = S_STOP;
                end else if (w_done_acc == c_all_ones) begin
                    w_state_next = S_IDLE;
                end
            end
            S_STOP: begin
                eng_stop     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_wr_addr   <= '0;
            r_ct_addr   <= '0;
            r_done_seen <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_found_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                        r_found_idx <= '0;
                        r_ct_addr   <= '0;
                        r_wr_addr   <= '0;
                    end
                end
                S_RDLEN: begin
                    r_ct_addr <= AW'(1);
                end
                S_COPY: begin
                    if (r_wr_addr == '0) begin
                        r_len <= w_rd_len;
                    end
                    if (!w_last_wr) begin
                        r_wr_addr <= r_wr_addr + AW'(1);
                    end
                    // Read address saturates at L so it never wraps.
                    if (r_ct_addr < w_len) begin
                        r_ct_addr <= r_ct_addr + AW'(1);
                    end
                end
                S_START: begin
                    r_done_seen <= '0;
                end
                S_RUN: begin
                    r_done_seen <= w_done_acc;
                    if (w_hit) begin
                        r_key       <= w_hit_key;
                        r_key_valid <= 1'b1;
                        r_found_idx <= w_hit_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ct_addr   = r_ct_addr;
    assign bc_addr   = r_wr_addr;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign found_idx = r_found_idx;

endmodule
`default_nettype wire

// File: tb/tb_multicrack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicrack_ctrl
// Brief    : Randomised scoreboard bench for multicrack_ctrl with four engines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicrack_ctrl;

    localparam int N_ENG = 4;
    localparam int KEY_W = 24;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct packed {
        logic        v;
        logic [23:0] k;
        logic [1:0]  idx;
        logic [1:0]  stop;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   rdy;
    logic [KEY_W-1:0]       key;
    logic                   key_valid;
    logic [1:0]             found_idx;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_rddata;
    logic                   bc_wren;
    logic [7:0]             bc_addr;
    logic [7:0]             bc_wrdata;
    logic [N_ENG-1:0]       eng_start;
    logic                   eng_stop;
    logic [N_ENG-1:0]       eng_done;
    logic [N_ENG-1:0]       eng_key_valid;
    logic [N_ENG*KEY_W-1:0] eng_key;

    logic [7:0]  mem [256];
    wr_t         exp_wr[$];
    res_t        exp_res[$];
    int          sch_d [N_ENG];
    bit          sch_v [N_ENG];
    logic [23:0] sch_k [N_ENG];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tmo_cnt = 0;
    int tmo_seen = 0;
    bit end_req = 0;

    multicrack_ctrl #(.N_ENG(N_ENG), .KEY_W(KEY_W), .AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
        .key_valid(key_valid), .found_idx(found_idx), .ct_addr(ct_addr),
        .ct_rddata(ct_rddata), .bc_wren(bc_wren), .bc_addr(bc_addr),
        .bc_wrdata(bc_wrdata), .eng_start(eng_start), .eng_stop(eng_stop),
        .eng_done(eng_done), .eng_key_valid(eng_key_valid), .eng_key(eng_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        ct_rddata <= mem[ct_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit prev_rst = 0, prev_rdy = 1, prev_en = 0, prev_wren = 0;
    bit prev_start = 0, prev_kv = 0, prev_hit = 0, first_pending = 0;
    int fall_cyc = 0, stop_cnt = 0;

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (prev_rst) begin
            chk("rst_rdy", rdy, 1);
            chk("rst_key", key, 0);
            chk("rst_key_valid", key_valid, 0);
            chk("rst_found_idx", found_idx, 0);
            chk("rst_ct_addr", ct_addr, 0);
            chk("rst_bc_wren", bc_wren, 0);
            chk("rst_bc_addr", bc_addr, 0);
            chk("rst_bc_wrdata", bc_wrdata, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_eng_stop", eng_stop, 0);
            stop_cnt = 0;
            first_pending = 0;
        end else begin
            if (prev_en && prev_rdy) chk("rdy_low_after_en", rdy, 0);
            if (!rdy && prev_rdy) begin
                fall_cyc = cyc;
                first_pending = 1;
            end
            if (bc_wren) begin
                if (first_pending) begin
                    chk("first_wr_latency", 64'(cyc - fall_cyc), 1);
                    first_pending = 0;
                end
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 64'(exp_wr.size()), 1);
                end else begin
                    w = exp_wr.pop_front();
                    chk("bc_addr", bc_addr, w.a);
                    chk("bc_wrdata", bc_wrdata, w.d);
                end
            end
            if (eng_start != 0) begin
                chk("start_bits", eng_start, 4'hF);
                chk("start_after_last_wr", prev_wren, 1);
                chk("start_writes_left", 64'(exp_wr.size()), 0);
                chk("start_one_cycle", prev_start, 0);
            end
            if (eng_stop) stop_cnt++;
            if (key_valid && !prev_kv) chk("kv_latency", prev_hit, 1);
            if (rdy && !prev_rdy) begin
                if (exp_res.size() == 0) begin
                    chk("res_unexpected", 64'(exp_res.size()), 1);
                end else begin
                    r = exp_res.pop_front();
                    chk("key_valid", key_valid, r.v);
                    chk("key", key, r.k);
                    chk("found_idx", found_idx, r.idx);
                    chk("eng_stop_count", 64'(stop_cnt), 64'(r.stop));
                end
                stop_cnt = 0;
            end
        end
        if (tmo_cnt != tmo_seen) begin
            chk("wait_timeout", 64'(tmo_cnt), 64'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (end_req) begin
            chk("writes_left_at_end", 64'(exp_wr.size()), 0);
            chk("results_left_at_end", 64'(exp_res.size()), 0);
            end_req = 0;
        end
        prev_rst   = rst;
        prev_rdy   = rdy;
        prev_en    = en;
        prev_wren  = bc_wren;
        prev_start = (eng_start != 0);
        prev_kv    = key_valid;
        prev_hit   = ((eng_done & eng_key_valid) != 0);
    end

    // ---------------- stimulus ----------------
    task automatic pulse_en();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic do_search(input int len, input bit fill, input bit en_in_run);
        int   best, bestd, maxd, n;
        bit   got;
        res_t r;
        if (fill) begin
            mem[0] = 8'(len);
            for (int k = 1; k <= len; k++) mem[k] = 8'($urandom);
        end
        for (int k = 0; k <= len; k++) exp_wr.push_back({8'(k), mem[k]});
        // Reference: earliest valid finisher wins, ties go to the lower index.
        best = -1; bestd = 1000; maxd = 0;
        for (int i = 0; i < N_ENG; i++) begin
            if (sch_d[i] > maxd) maxd = sch_d[i];
            if (sch_v[i] && sch_d[i] < bestd) begin
                best = i;
                bestd = sch_d[i];
            end
        end
        r.v    = (best >= 0);
        r.k    = (best >= 0) ? sch_k[best] : 24'h0;
        r.idx  = (best >= 0) ? 2'(best) : 2'd0;
        r.stop = (best >= 0) ? 2'd1 : 2'd0;
        exp_res.push_back(r);

        pulse_en();
        got = 0;
        for (n = 0; n < 600 && !got; n++) begin
            @(posedge clk); #1;
            if (eng_start != 0) got = 1;
        end
        if (!got) begin
            tmo_cnt++;
            return;
        end
        for (int t = 1; t <= maxd; t++) begin
            @(posedge clk); #1;
            en = en_in_run && (t == 1);
            for (int i = 0; i < N_ENG; i++) begin
                eng_done[i]             = (sch_d[i] == t);
                eng_key_valid[i]        = (sch_d[i] == t) ? sch_v[i] : 1'($urandom);
                eng_key[i*KEY_W +: KEY_W] = (sch_d[i] == t) ? sch_k[i] : 24'($urandom);
            end
        end
        @(posedge clk); #1;
        en = 1'b0;
        eng_done = '0;
        eng_key_valid = '0;
        got = 0;
        for (n = 0; n < 40 && !got; n++) begin
            if (rdy) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!got) tmo_cnt++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_sched(input int d0, d1, d2, d3, input bit v0, v1, v2, v3);
        sch_d[0] = d0; sch_d[1] = d1; sch_d[2] = d2; sch_d[3] = d3;
        sch_v[0] = v0; sch_v[1] = v1; sch_v[2] = v2; sch_v[3] = v3;
        for (int i = 0; i < N_ENG; i++) sch_k[i] = 24'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        eng_done = '0;
        eng_key_valid = '0;
        eng_key = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Engine 2 alone finds key 0x00ABCD.
        mem[0] = 8'd3; mem[1] = 8'hA1; mem[2] = 8'hB2; mem[3] = 8'hC3;
        set_sched(5, 6, 3, 7, 0, 0, 1, 0);
        sch_k[2] = 24'h00ABCD;
        do_search(3, 0, 0);

        // Engines 1 and 3 hit together: lower index wins.
        set_sched(4, 2, 5, 2, 0, 1, 0, 1);
        sch_k[1] = 24'h000111;
        sch_k[3] = 24'h000333;
        do_search(5, 1, 0);

        // Every engine exhausts its range without a key.
        set_sched(1, 4, 2, 6, 0, 0, 0, 0);
        do_search(4, 1, 0);

        // Reset in the middle of the copy, after two broadcast writes.
        mem[0] = 8'd10;
        for (int k = 1; k <= 10; k++) mem[k] = 8'($urandom);
        exp_wr.push_back({8'd0, mem[0]});
        exp_wr.push_back({8'd1, mem[1]});
        pulse_en();
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Zero-length ciphertext: single write of the length byte.
        set_sched(2, 3, 1, 2, 0, 1, 0, 0);
        do_search(0, 1, 0);

        // en raised during RUN must not start another search.
        set_sched(3, 3, 3, 3, 0, 0, 0, 1);
        do_search(6, 1, 1);

        // Full-range length exercising the non-wrapping address counter.
        set_sched(2, 1, 2, 3, 1, 0, 0, 1);
        do_search(255, 1, 0);

        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N_ENG; i++) begin
                sch_d[i] = $urandom_range(1, 12);
                sch_v[i] = ($urandom_range(0, 3) == 0);
                sch_k[i] = 24'($urandom);
            end
            do_search($urandom_range(0, 24), 1, 1'($urandom_range(0, 1)));
        end

        end_req = 1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
